// File: rtl/uart_tx_arbiter_if.sv
// Bundle of request, grant and byte-UART handshake signals for uart_tx_arbiter.
// slave is the arbiter side; master is the requesters plus byte UART side.
interface uart_tx_arbiter_if;
    logic [2:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        err;
    logic        busy;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_done;

    modport slave (
        input  req, data0, data1, data2, tx_done,
        output gnt, done, err, busy, tx_start, tx_byte
    );

    modport master (
        output req, data0, data1, data2, tx_done,
        input  gnt, done, err, busy, tx_start, tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises one 32-bit word from one of three
// requesters into four bytes for a byte-wide UART, with a per-byte timeout.
module uart_tx_arbiter #(
    parameter int unsigned LSB_FIRST = 1,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;

    state_t      state_q, state_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [2:0]  done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] tocnt_q, tocnt_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  winner_q, winner_d;

    logic [1:0]  cand0, cand1, cand2, pick;
    logic [7:0]  next_byte;
    logic [31:0] shifted;
    logic [16:0] to_inc;

    function automatic logic [1:0] rr_next(input logic [1:0] x);
        return (x >= 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_byte  = tx_byte_q;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        err_d      = 1'b0;
        busy_d     = busy_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        tocnt_d    = tocnt_q;
        last_d     = last_q;
        winner_d   = winner_q;

        // search order starts one past the last served requester
        cand0 = rr_next(last_q);
        cand1 = rr_next(cand0);
        cand2 = rr_next(cand1);
        if (bus.req[cand0])
            pick = cand0;
        else if (bus.req[cand1])
            pick = cand1;
        else
            pick = cand2;

        if (LSB_FIRST != 0) begin
            next_byte = shreg_q[7:0];
            shifted   = {8'h00, shreg_q[31:8]};
        end else begin
            next_byte = shreg_q[31:24];
            shifted   = {shreg_q[23:0], 8'h00};
        end

        to_inc = {1'b0, tocnt_q} + 17'd1;

        case (state_q)
            IDLE: begin
                if (bus.req != 3'b000) begin
                    winner_d   = pick;
                    gnt_d      = 3'b001 << pick;
                    byte_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = SEND;
                    case (pick)
                        2'd0:    shreg_d = bus.data0;
                        2'd1:    shreg_d = bus.data1;
                        default: shreg_d = bus.data2;
                    endcase
                end
            end
            SEND: begin
                tx_start_d = 1'b1;
                tx_byte_d  = next_byte;
                tocnt_d    = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // tx_done is checked first so it wins over a simultaneous timeout
                if (bus.tx_done) begin
                    if (byte_cnt_q == 2'd3) begin
                        state_d = FIN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        shreg_d    = shifted;
                        state_d    = SEND;
                    end
                end else if (to_inc >= {1'b0, TIMEOUT}) begin
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    last_d  = winner_q;
                    state_d = IDLE;
                end else begin
                    tocnt_d = to_inc[15:0];
                end
            end
            FIN: begin
                done_d  = gnt_q;
                gnt_d   = '0;
                busy_d  = 1'b0;
                last_d  = winner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            tocnt_q    <= '0;
            last_q     <= 2'd2;
            winner_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            tocnt_q    <= tocnt_d;
            last_q     <= last_d;
            winner_q   <= winner_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one LSB-first instance with TIMEOUT=20
// and one MSB-first instance, each with a byte-UART responder model.
module tb_uart_tx_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    // Cycle index used to timestamp observed events.
    always @(posedge clk) cyc++;

    uart_tx_arbiter_if a_if ();
    uart_tx_arbiter_if b_if ();

    uart_tx_arbiter #(.LSB_FIRST(1), .TIMEOUT(16'd20)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    uart_tx_arbiter #(.LSB_FIRST(0), .TIMEOUT(16'hFFFF)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    logic [7:0] a_bytes[$];
    logic [2:0] a_start_gnt[$];
    int         a_start_cyc[$];
    logic [2:0] a_done_q[$];
    int         a_done_cyc[$];
    int         a_err_cyc[$];
    logic [2:0] a_err_gnt[$];
    logic       a_err_busy[$];
    logic [2:0] a_gnt_q[$];
    int         a_gnt_cyc[$];
    logic [2:0] a_prev_gnt = '0;
    int         a_cnt      = 0;
    bit         a_en       = 1'b1;
    int         a_multi    = 0;

    logic [7:0] b_bytes[$];
    logic [2:0] b_done_q[$];
    int         b_cnt = 0;

    logic [2:0] rr_order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Byte UART model for instance A (tx_done 10 cycles after tx_start) plus event log.
    always @(negedge clk) begin
        a_if.tx_done = 1'b0;
        if (!reset)
            a_cnt = 0;
        else if (a_cnt > 0) begin
            a_cnt--;
            if (a_cnt == 0) a_if.tx_done = 1'b1;
        end
        if (a_if.tx_start) begin
            a_bytes.push_back(a_if.tx_byte);
            a_start_gnt.push_back(a_if.gnt);
            a_start_cyc.push_back(cyc);
            if (a_en) a_cnt = 10;
        end
        if (a_if.done != 3'b000) begin
            a_done_q.push_back(a_if.done);
            a_done_cyc.push_back(cyc);
        end
        if (a_if.err) begin
            a_err_cyc.push_back(cyc);
            a_err_gnt.push_back(a_if.gnt);
            a_err_busy.push_back(a_if.busy);
        end
        if (a_if.gnt != 3'b000 && a_prev_gnt == 3'b000) begin
            a_gnt_q.push_back(a_if.gnt);
            a_gnt_cyc.push_back(cyc);
        end
        a_prev_gnt = a_if.gnt;
        if (!$onehot0(a_if.gnt) || !$onehot0(a_if.done)) a_multi++;
    end

    // Byte UART model for instance B (tx_done 3 cycles after tx_start).
    always @(negedge clk) begin
        b_if.tx_done = 1'b0;
        if (!reset)
            b_cnt = 0;
        else if (b_cnt > 0) begin
            b_cnt--;
            if (b_cnt == 0) b_if.tx_done = 1'b1;
        end
        if (b_if.tx_start) begin
            b_bytes.push_back(b_if.tx_byte);
            b_cnt = 3;
        end
        if (b_if.done != 3'b000) b_done_q.push_back(b_if.done);
    end

    initial begin
        int bs, bd, bg, be;

        a_if.req = '0; a_if.data0 = '0; a_if.data1 = '0; a_if.data2 = '0;
        b_if.req = '0; b_if.data0 = '0; b_if.data1 = '0; b_if.data2 = '0;

        // reset values
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt",      a_if.gnt,      0);
        check("rst_done",     a_if.done,     0);
        check("rst_err",      a_if.err,      0);
        check("rst_busy",     a_if.busy,     0);
        check("rst_tx_start", a_if.tx_start, 0);
        check("rst_tx_byte",  a_if.tx_byte,  0);
        reset = 1'b1;
        @(negedge clk);

        // single word, LSB first
        bs = a_bytes.size(); bd = a_done_q.size();
        a_if.data0 = 32'h04030201;
        a_if.req   = 3'b001;
        @(negedge clk);
        check("t1_gnt_next_cycle", a_if.gnt, 3'b001);
        check("t1_busy", a_if.busy, 1);
        a_if.req = 3'b000;
        for (int i = 0; i < 200 && a_done_q.size() <= bd; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("t1_done_count", a_done_q.size() - bd, 1);
        check("t1_done_val",   a_done_q[bd], 3'b001);
        check("t1_byte_count", a_bytes.size() - bs, 4);
        check("t1_byte0", a_bytes[bs],   8'h01);
        check("t1_byte1", a_bytes[bs+1], 8'h02);
        check("t1_byte2", a_bytes[bs+2], 8'h03);
        check("t1_byte3", a_bytes[bs+3], 8'h04);
        for (int k = 0; k < 4; k++) check("t1_gnt_at_start", a_start_gnt[bs+k], 3'b001);
        check("t1_start_spacing", a_start_cyc[bs+1] - a_start_cyc[bs], 12);

        // contention from a fresh reset
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        bg = a_gnt_q.size(); bd = a_done_q.size();
        a_if.data0 = 32'h10101010; a_if.data1 = 32'h20202020; a_if.data2 = 32'h30303030;
        a_if.req = 3'b111;
        for (int i = 0; i < 400 && a_gnt_q.size() < bg + 4; i++) @(negedge clk);
        a_if.req = 3'b000;
        for (int i = 0; i < 200 && a_done_q.size() < bd + 4; i++) @(negedge clk);
        check("t2_grant_count", a_gnt_q.size() - bg, 4);
        check("t2_done_count",  a_done_q.size() - bd, 4);
        for (int k = 0; k < 4; k++) begin
            check("t2_grant_order", a_gnt_q[bg+k], rr_order[k]);
            check("t2_done_order",  a_done_q[bd+k], rr_order[k]);
        end
        for (int k = 0; k < 3; k++)
            check("t2_done_before_gnt", (a_gnt_cyc[bg+k+1] - a_done_cyc[bd+k]) >= 1, 1);

        // timeout with no tx_done, then the next request is served
        repeat (3) @(negedge clk);
        a_en = 1'b0;
        bs = a_start_cyc.size(); bd = a_done_q.size(); be = a_err_cyc.size();
        a_if.req = 3'b001;
        @(negedge clk);
        check("t3_gnt", a_if.gnt, 3'b001);
        a_if.req = 3'b000;
        for (int i = 0; i < 100 && a_err_cyc.size() <= be; i++) @(negedge clk);
        check("t3_err_count",   a_err_cyc.size() - be, 1);
        check("t3_err_latency", a_err_cyc[be] - a_start_cyc[bs], 20);
        check("t3_err_gnt",     a_err_gnt[be], 0);
        check("t3_err_busy",    a_err_busy[be], 0);
        check("t3_no_done",     a_done_q.size() - bd, 0);
        check("t3_one_start",   a_start_cyc.size() - bs, 1);
        a_en = 1'b1;
        bd = a_done_q.size();
        a_if.data1 = 32'h11223344;
        a_if.req   = 3'b010;
        @(negedge clk);
        check("t3_next_gnt", a_if.gnt, 3'b010);
        a_if.req = 3'b000;
        for (int i = 0; i < 200 && a_done_q.size() <= bd; i++) @(negedge clk);
        check("t3_next_done", a_done_q.size() > bd ? a_done_q[bd] : 3'b000, 3'b010);

        // data change and req drop after grant
        repeat (2) @(negedge clk);
        bs = a_bytes.size(); bd = a_done_q.size();
        a_if.data2 = 32'hDEADBEEF;
        a_if.req   = 3'b100;
        @(negedge clk);
        check("t4_gnt", a_if.gnt, 3'b100);
        a_if.data2 = 32'h00000000;
        a_if.req   = 3'b000;
        for (int i = 0; i < 200 && a_done_q.size() <= bd; i++) @(negedge clk);
        check("t4_byte0", a_bytes[bs],   8'hEF);
        check("t4_byte1", a_bytes[bs+1], 8'hBE);
        check("t4_byte2", a_bytes[bs+2], 8'hAD);
        check("t4_byte3", a_bytes[bs+3], 8'hDE);
        check("t4_done",  a_done_q.size() > bd ? a_done_q[bd] : 3'b000, 3'b100);

        // reset in the middle of a word
        repeat (2) @(negedge clk);
        bs = a_bytes.size(); bd = a_done_q.size(); be = a_err_cyc.size();
        a_if.data2 = 32'h87654321;
        a_if.req   = 3'b100;
        for (int i = 0; i < 100 && a_bytes.size() < bs + 2; i++) @(negedge clk);
        check("t5_two_bytes", a_bytes.size() - bs, 2);
        #2 reset = 1'b0;
        #1;
        check("t5_async_gnt",      a_if.gnt,      0);
        check("t5_async_done",     a_if.done,     0);
        check("t5_async_err",      a_if.err,      0);
        check("t5_async_busy",     a_if.busy,     0);
        check("t5_async_tx_start", a_if.tx_start, 0);
        check("t5_async_tx_byte",  a_if.tx_byte,  0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_regrant", a_if.gnt, 3'b100);
        check("t5_no_done", a_done_q.size() - bd, 0);
        check("t5_no_err",  a_err_cyc.size() - be, 0);
        a_if.req = 3'b000;
        for (int i = 0; i < 200 && a_done_q.size() <= bd; i++) @(negedge clk);
        check("t5_restart_byte", a_bytes[bs+2], 8'h21);
        check("t5_done", a_done_q.size() > bd ? a_done_q[bd] : 3'b000, 3'b100);

        // MSB-first instance
        bs = b_bytes.size(); bd = b_done_q.size();
        b_if.data1 = 32'hAABBCCDD;
        b_if.req   = 3'b010;
        @(negedge clk);
        check("t6_gnt", b_if.gnt, 3'b010);
        b_if.req = 3'b000;
        for (int i = 0; i < 100 && b_done_q.size() <= bd; i++) @(negedge clk);
        check("t6_byte0", b_bytes[bs],   8'hAA);
        check("t6_byte1", b_bytes[bs+1], 8'hBB);
        check("t6_byte2", b_bytes[bs+2], 8'hCC);
        check("t6_byte3", b_bytes[bs+3], 8'hDD);
        check("t6_done",  b_done_q.size() > bd ? b_done_q[bd] : 3'b000, 3'b010);

        check("no_multi_hot", a_multi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
